// File: rtl/shift_reg_gated_elastic.sv
// rtl/shift_reg_gated_elastic.sv - elastic Depth-stage pipeline with per-stage valid, bubble collapse, flush and occupancy count
// Optional macro SHIFT_REG_GATED_ELASTIC_FLUSH_CLR_EN: flush also zeroes the data registers.
module shift_reg_gated_elastic #(
  parameter int unsigned Depth = 32'd4,
  parameter type dtype = logic,
  localparam int unsigned CntWidth = (Depth > 0) ? $clog2(Depth + 1) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  dtype                data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output dtype                data_o,
  output logic [CntWidth-1:0] count_o
);

  if (Depth == 0) begin : g_passthru

    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk_i, rst_i};

    assign valid_o = valid_i & ~flush_i;
    assign data_o  = data_i;
    assign ready_o = ready_i & ~flush_i;
    assign count_o = '0;

  end else begin : g_pipe

    logic [Depth-1:0]    valid_q;
    logic [Depth-1:0]    valid_d;
    dtype                data_q [Depth];
    dtype                data_d [Depth];
    logic [Depth:0]      adv;
    logic [CntWidth-1:0] count_q;
    logic [CntWidth-1:0] count_d;
    logic                in_xfer;
    logic                out_xfer;

    // Next-stage inputs: stage 0 takes the upstream beat, others take their predecessor.
    for (genvar k = 0; k < Depth; k++) begin : g_stage_in
      if (k == 0) begin : g_head
        assign valid_d[k] = valid_i & ~flush_i;
        assign data_d[k]  = data_i;
      end else begin : g_body
        assign valid_d[k] = valid_q[k-1];
        assign data_d[k]  = data_q[k-1];
      end
    end

    // Advance chain: a stage may move if it is empty or the stage after it moves.
    always_comb begin
      logic acc;
      adv        = '0;
      acc        = ready_i;
      adv[Depth] = ready_i;
      for (int k = int'(Depth) - 1; k >= 0; k--) begin
        acc    = ~valid_q[k] | acc;
        adv[k] = acc;
      end
    end

    assign ready_o  = adv[0] & ~flush_i;
    assign valid_o  = valid_q[Depth-1];
    assign data_o   = data_q[Depth-1];
    assign count_o  = count_q;
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    // Occupancy follows transfers; simultaneous in/out leaves it unchanged.
    always_comb begin
      count_d = count_q;
      if (in_xfer && !out_xfer) begin
        count_d = count_q + CntWidth'(1);
      end else if (!in_xfer && out_xfer) begin
        count_d = count_q - CntWidth'(1);
      end
    end

    // Valid flags and count: reset/flush empty the pipe, otherwise each advancing stage samples its input.
    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        valid_q <= '0;
        count_q <= '0;
      end else begin
        for (int k = 0; k < int'(Depth); k++) begin
          if (adv[k]) begin
            valid_q[k] <= valid_d[k];
          end
        end
        count_q <= count_d;
      end
    end

    // Payload registers load only when a valid beat enters, giving a clean clock-gate enable.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int k = 0; k < int'(Depth); k++) begin
          data_q[k] <= '0;
        end
`ifdef SHIFT_REG_GATED_ELASTIC_FLUSH_CLR_EN
      end else if (flush_i) begin
        for (int k = 0; k < int'(Depth); k++) begin
          data_q[k] <= '0;
        end
`endif
      end else if (!flush_i) begin
        for (int k = 0; k < int'(Depth); k++) begin
          if (adv[k] && valid_d[k]) begin
            data_q[k] <= data_d[k];
          end
        end
      end
    end

  end

endmodule

// File: tb/tb_shift_reg_gated_elastic.sv
// tb/tb_shift_reg_gated_elastic.sv - scoreboard bench for shift_reg_gated_elastic (Depth 4 and Depth 0)
module tb_shift_reg_gated_elastic;

  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i   = 1'b1;
  logic       flush_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b0;
  logic [7:0] data_i  = 8'h00;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic [2:0] count_o;

  logic       z_valid_i = 1'b0;
  logic       z_flush_i = 1'b0;
  logic       z_ready_i = 1'b0;
  logic [7:0] z_data_i  = 8'h00;
  logic       z_ready_o;
  logic       z_valid_o;
  logic [7:0] z_data_o;
  logic [0:0] z_count_o;
  bit         z_en = 1'b0;

  shift_reg_gated_elastic #(.Depth(D), .dtype(logic [7:0])) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .count_o(count_o)
  );

  shift_reg_gated_elastic #(.Depth(0), .dtype(logic [7:0])) dut0 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(z_flush_i),
    .valid_i(z_valid_i), .ready_o(z_ready_o), .data_i(z_data_i),
    .valid_o(z_valid_o), .ready_i(z_ready_i), .data_o(z_data_o),
    .count_o(z_count_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats in flight in arrival order, each with the edge at which it was accepted.
  typedef struct {
    logic [7:0] d;
    int         acc;
  } item_t;
  item_t      q[$];
  int         ecnt      = 0;
  int         last_out  = 0;
  logic [7:0] last_pres = 8'h00;
  bit         model_ok  = 1'b0;

  // Upstream stimulus: bit 8 set means one idle cycle.
  logic [8:0] tx[$];
  bit         pop_next = 1'b0;

  always @(posedge clk) ecnt++;

  // Monitor: compare DUT outputs to the model mid-cycle, then apply the coming edge to the model.
  always @(negedge clk) begin : mon
    bit exp_v;
    bit exp_r;
    bit in_x;
    bit out_x;
    int arr;
    exp_v = 1'b0;
    if (q.size() > 0) begin
      arr = q[0].acc + D - 1;
      if (last_out > arr) arr = last_out;
      exp_v = (ecnt >= arr);
    end
    exp_r = !flush_i && !(q.size() == D && !ready_i);
    if (model_ok) begin
      chk("valid_o", valid_o, exp_v);
      chk("data_o", data_o, exp_v ? q[0].d : last_pres);
      chk("count_o", count_o, q.size());
      chk("ready_o", ready_o, exp_r);
    end
    chk("z_valid_o", z_valid_o, z_valid_i & ~z_flush_i);
    chk("z_data_o", z_data_o, z_data_i);
    chk("z_ready_o", z_ready_o, z_ready_i & ~z_flush_i);
    chk("z_count_o", z_count_o, 0);

    in_x  = valid_i && exp_r && !rst_i && model_ok;
    out_x = exp_v && ready_i && !rst_i;
    if (rst_i) begin
      q.delete();
      last_pres = 8'h00;
      last_out  = 0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      if (exp_v) last_pres = q[0].d;
      if (out_x) begin
        void'(q.pop_front());
        last_out = ecnt + 1;
      end
      if (flush_i) begin
        q.delete();
`ifdef SHIFT_REG_GATED_ELASTIC_FLUSH_CLR_EN
        last_pres = 8'h00;
`endif
      end else if (in_x) begin
        q.push_back('{d: data_i, acc: ecnt + 1});
      end
    end
    if (in_x) pop_next = 1'b1;
  end

  // Driver: presents queued beats and holds each one until it is accepted.
  always @(posedge clk) begin
    #1;
    if (pop_next) begin
      if (tx.size() > 0) void'(tx.pop_front());
      pop_next = 1'b0;
    end
    if (tx.size() == 0) begin
      valid_i = 1'b0;
    end else if (tx[0][8]) begin
      valid_i  = 1'b0;
      pop_next = 1'b1;
    end else begin
      valid_i = 1'b1;
      data_i  = tx[0][7:0];
    end
    if (z_en) begin
      z_valid_i = 1'($urandom_range(0, 1));
      z_ready_i = 1'($urandom_range(0, 1));
      z_flush_i = ($urandom_range(0, 3) == 0);
      z_data_i  = 8'($urandom);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name, input int lim);
    int n;
    n = 0;
    ready_i = 1'b1;
    flush_i = 1'b0;
    rst_i   = 1'b0;
    while ((tx.size() != 0 || q.size() != 0 || valid_i) && n < lim) begin
      tick(1);
      n++;
    end
    chk({"drain_timeout_", name}, (n >= lim), 0);
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    // Depth 0: pure combinational pass-through.
    z_valid_i = 1'b1; z_data_i = 8'h5A; z_ready_i = 1'b0; z_flush_i = 1'b0;
    #1;
    chk("z0_valid", z_valid_o, 1);
    chk("z0_data", z_data_o, 8'h5A);
    chk("z0_ready", z_ready_o, 0);
    chk("z0_count", z_count_o, 0);
    z_flush_i = 1'b1; z_ready_i = 1'b1;
    #1;
    chk("z0_flush_valid", z_valid_o, 0);
    chk("z0_flush_ready", z_ready_o, 0);
    z_en = 1'b1;

    tick(2);
    rst_i   = 1'b0;
    ready_i = 1'b1;

    // Streaming 0x01..0x0A.
    for (int i = 1; i <= 10; i++) tx.push_back(9'(i));
    drain("stream", 60);

    // Bubbles collapse under a stalled output; 5th beat waits.
    ready_i = 1'b1;
    tx.push_back(9'h011); tx.push_back(9'h100); tx.push_back(9'h100);
    tx.push_back(9'h022); tx.push_back(9'h033); tx.push_back(9'h044); tx.push_back(9'h055);
    tick(3);
    ready_i = 1'b0;
    tick(12);
    chk("stall_count", count_o, 4);
    chk("stall_ready", ready_o, 0);
    chk("stall_pending", valid_i, 1);
    drain("stall", 60);

    // Full pipe with simultaneous in/out.
    ready_i = 1'b0;
    for (int i = 0; i < 12; i++) tx.push_back(9'(8'hA0 + i));
    tick(8);
    chk("full_count", count_o, 4);
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("thru_count", count_o, 4);
      chk("thru_ready", ready_o, 1);
    end
    drain("full", 60);

    // Flush with three beats held.
    ready_i = 1'b0;
    tx.push_back(9'h0C1); tx.push_back(9'h0C2); tx.push_back(9'h0C3);
    tick(8);
    chk("preflush_count", count_o, 3);
    ready_i = 1'b1;
    flush_i = 1'b1;
    #1;
    chk("flush_ready", ready_o, 0);
    chk("flush_head_valid", valid_o, 1);
    chk("flush_head_data", data_o, 8'hC1);
    tick(1);
    flush_i = 1'b0;
    #1;
    chk("postflush_valid", valid_o, 0);
    chk("postflush_count", count_o, 0);
`ifdef SHIFT_REG_GATED_ELASTIC_FLUSH_CLR_EN
    chk("postflush_data", data_o, 8'h00);
`else
    chk("postflush_data", data_o, 8'hC1);
`endif
    drain("flush", 40);

    // Reset mid-operation together with flush.
    ready_i = 1'b0;
    tx.push_back(9'h0D1); tx.push_back(9'h0D2);
    tick(8);
    chk("prereset_count", count_o, 2);
    rst_i   = 1'b1;
    flush_i = 1'b1;
    tick(1);
    rst_i   = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("reset_valid", valid_o, 0);
    chk("reset_data", data_o, 8'h00);
    chk("reset_count", count_o, 0);
    chk("reset_ready", ready_o, 1);
    for (int i = 0; i < 5; i++) tx.push_back(9'(8'hE0 + i));
    drain("reset", 60);

    // Randomized traffic, backpressure, flushes and resets.
    for (int c = 0; c < 3000; c++) begin
      ready_i = ($urandom_range(0, 9) < 7);
      flush_i = ($urandom_range(0, 39) == 0);
      rst_i   = ($urandom_range(0, 199) == 0);
      if (tx.size() < 3) begin
        if ($urandom_range(0, 3) == 0) tx.push_back(9'h100);
        else tx.push_back({1'b0, 8'($urandom)});
      end
      tick(1);
    end
    drain("random", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
